// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared widths, FSM encoding and buffer entry layout for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam int          INST_W    = 32;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam int          BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } buf_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo2.sv
// ============================================================================
// Module      : ifetch_fifo2
// Description : Two-entry synchronous FIFO with flush; head is visible
//               combinationally. Push on a full FIFO is accepted only together
//               with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo2
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // Full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Fetch stage driving the PC register, issuing imem requests and
//               buffering {pc, inst} for decode; squashes stale responses on
//               redirect. Optional macro IFETCH_BYPASS_EN forwards a response
//               straight to decode when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic RESET_EPOCH     = 1'b0,
    parameter int   OUTSTANDING_MAX = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [INST_W-1:0] pc_q,
    output logic [INST_W-1:0] pc_d,
    output logic              pc_en,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [INST_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [INST_W-1:0] inst_pc
);

    fetch_state_e      state_q, state_d;
    logic [1:0]        discard_q, discard_d;
    logic              epoch_q, epoch_d;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              bypass;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_nonempty;
    logic [1:0]        ifq_count;
    logic [1:0]        buf_count;
    logic [2:0]        credit_used;
    logic [INST_W:0]   ifq_head;
    buf_entry_t        buf_head;
    buf_entry_t        rsp_entry;

    // Credits cover both outstanding requests and buffered instructions.
    assign credit_used    = {1'b0, ifq_count} + {1'b0, buf_count};
    assign imem_req_valid = !arst && !redirect_valid && (int'(credit_used) < OUTSTANDING_MAX);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign pc_en = !arst && (redirect_valid || req_fire);
    assign pc_d  = redirect_valid ? align_pc(redirect_pc) : pc_q + PC_INC;

    assign rsp_fire  = imem_rsp_valid && (ifq_count != 2'd0);
    assign rsp_keep  = rsp_fire && !redirect_valid && (state_q != ST_DRAIN);
    assign rsp_entry = '{pc: ifq_head[INST_W-1:0], inst: imem_rsp_data};

    assign buf_nonempty = (buf_count != 2'd0);

`ifdef IFETCH_BYPASS_EN
    assign bypass = rsp_keep && !buf_nonempty && inst_ready;
`else
    assign bypass = 1'b0;
`endif

    assign buf_push   = rsp_keep && !bypass;
    assign buf_pop    = inst_ready && buf_nonempty;
    assign inst_valid = buf_nonempty || bypass;
    assign inst_pc    = buf_nonempty ? buf_head.pc   : rsp_entry.pc;
    assign inst_data  = buf_nonempty ? buf_head.inst : rsp_entry.inst;

    // A response landing in the redirect cycle is itself stale, so it is
    // subtracted from the count still to be thrown away.
    always_comb begin
        discard_d = discard_q;
        epoch_d   = epoch_q;
        if (redirect_valid) begin
            discard_d = ifq_count - {1'b0, rsp_fire};
            epoch_d   = ~epoch_q;
        end else if (rsp_fire && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
        state_d = (discard_d != 2'd0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_RESET;
            discard_q <= 2'd0;
            epoch_q   <= RESET_EPOCH;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            epoch_q   <= epoch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            assert (!(imem_rsp_valid && (ifq_count == 2'd0)))
                else $error("ifetch_unit: response with no request in flight");
            assert (!(rsp_fire && (state_q != ST_DRAIN)) || (ifq_head[INST_W] == epoch_q))
                else $error("ifetch_unit: accepted response carries a stale epoch tag");
        end
    end

    ifetch_fifo2 #(.WIDTH(INST_W + 1)) u_inflight_q (
        .clk     (clk),
        .arst    (arst),
        .push_i  (req_fire),
        .pop_i   (rsp_fire),
        .flush_i (1'b0),
        .data_i  ({epoch_q, pc_q}),
        .data_o  (ifq_head),
        .count_o (ifq_count)
    );

    ifetch_fifo2 #(.WIDTH($bits(buf_entry_t))) u_inst_buf (
        .clk     (clk),
        .arst    (arst),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (redirect_valid),
        .data_i  (rsp_entry),
        .data_o  (buf_head),
        .count_o (buf_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit: the bench acts as PC
//               register and instruction memory, and compares against a
//               generation-tagged request/buffer model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

    logic        clk            = 1'b0;
    logic        arst           = 1'b0;
    logic [31:0] pc_q           = 32'h0040_0000;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        inst_ready     = 1'b0;
    logic [31:0] pc_d;
    logic        pc_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    ifetch_unit #(.RESET_EPOCH(1'b0), .OUTSTANDING_MAX(2)) dut (
        .clk            (clk),
        .arst           (arst),
        .pc_q           (pc_q),
        .pc_d           (pc_d),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: requests carry the redirect generation they were issued in;
    // a response is delivered only if no redirect has happened since.
    logic [63:0] bq[$];
    int          gens[$];
    logic [31:0] mem_pc[$];
    int          mem_rdy[$];
    int          cur_gen = 0;
    int          cyc     = 0;
    logic [31:0] pc_reg  = 32'h0040_0000;
    int          lat_lo  = 1;
    int          lat_hi  = 1;

    logic        s_req_valid, s_inst_valid, s_pc_en;
    logic [31:0] s_req_addr, s_pc_d, s_inst_pc, s_inst_data;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s got timeout exp event within 40 cycles", name);
    endtask

    task automatic step(input logic rd, input logic [31:0] rpc, input logic rq_rdy, input logic in_rdy);
        logic        rsp, keep, byp, exp_rv, exp_iv, accept, exp_pen;
        logic [31:0] exp_ipc, exp_idata, exp_pd, rsp_pc;
        rsp    = 1'b0;
        rsp_pc = 32'h0;
        if (mem_pc.size() > 0) begin
            if (mem_rdy[0] <= cyc) begin
                rsp    = 1'b1;
                rsp_pc = mem_pc[0];
            end
        end
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(rsp_pc) : $urandom;
        pc_q           = pc_reg;
        @(negedge clk);

        keep = 1'b0;
        if (rsp && !rd) keep = (gens[0] == cur_gen);
        byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp = keep && (bq.size() == 0) && in_rdy;
`endif
        exp_rv    = !rd && ((gens.size() + bq.size()) < 2);
        exp_iv    = (bq.size() > 0) || byp;
        exp_ipc   = (bq.size() > 0) ? bq[0][63:32] : rsp_pc;
        exp_idata = (bq.size() > 0) ? bq[0][31:0]  : mem_data(rsp_pc);
        accept    = exp_rv && rq_rdy;
        exp_pen   = rd || accept;
        exp_pd    = rd ? ((rpc >> 2) << 2) : pc_reg + 32'd4;

        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_pc_en     = pc_en;
        s_pc_d      = pc_d;
        s_inst_valid = inst_valid;
        s_inst_pc   = inst_pc;
        s_inst_data = inst_data;

        chk("req_valid", s_req_valid, exp_rv);
        chk("req_addr",  s_req_addr,  pc_reg);
        chk("pc_en",     s_pc_en,     exp_pen);
        chk("pc_d",      s_pc_d,      exp_pd);
        chk("inst_valid", s_inst_valid, exp_iv);
        if (exp_iv) begin
            chk("inst_pc",   s_inst_pc,   exp_ipc);
            chk("inst_data", s_inst_data, exp_idata);
        end

        if (exp_iv && in_rdy && !byp) void'(bq.pop_front());
        if (rd) begin
            bq.delete();
            cur_gen++;
        end
        if (rsp) begin
            void'(gens.pop_front());
            void'(mem_pc.pop_front());
            void'(mem_rdy.pop_front());
            if (keep && !byp) bq.push_back({rsp_pc, mem_data(rsp_pc)});
        end
        if (accept) begin
            gens.push_back(cur_gen);
            mem_pc.push_back(pc_reg);
            mem_rdy.push_back(cyc + $urandom_range(lat_hi, lat_lo));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_pen) pc_reg = exp_pd;
    endtask

    task automatic do_reset();
        arst           = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("rst_req_valid",  imem_req_valid, 32'd0);
        chk("rst_inst_valid", inst_valid,     32'd0);
        chk("rst_pc_en",      pc_en,          32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_inst_valid", inst_valid, 32'd0);
        @(posedge clk);
        #1;
        cyc += 2;
        bq.delete();
        gens.delete();
        mem_pc.delete();
        mem_rdy.delete();
        pc_reg = 32'h0040_0000;
        pc_q   = pc_reg;
        arst   = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (gens.size() == 0 && bq.size() == 0) done = 1;
            else step(1'b0, 32'h0, 1'b0, 1'b1);
        end
        if (!done) fail_timeout("drain");
    endtask

    task automatic wait_inst(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_inst_valid === 1'b1) found = 1;
        end
        if (!found) fail_timeout(name);
        else begin
            chk({name, "_pc"},   s_inst_pc,   exp_pc);
            chk({name, "_data"}, s_inst_data, exp_pc ^ 32'h1234_5678);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish exp finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit hit;
        logic [31:0] r;
        #2;
        do_reset();

        // Straight-line fetch from 0x00400000 with 1-cycle memory.
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("first_req_valid", s_req_valid, 32'd1);
        chk("first_req_addr",  s_req_addr,  32'h0040_0000);
        wait_inst("first_inst", 32'h0040_0000);
        chk("first_inst_data_lit", s_inst_data, 32'h1274_5678);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stall: credits cap acceptance, nothing lost on release.
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (s_req_valid === 1'b1) acc++;
        end
        chk("stall_accepts_le2", 32'(acc <= 2), 32'd1);
        chk("stall_req_valid_off", s_req_valid, 32'd0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight.
        drain();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0040_0102, 1'b1, 1'b1);
        chk("redir_pc_d",  s_pc_d,  32'h0040_0100);
        chk("redir_pc_en", s_pc_en, 32'd1);
        wait_inst("redir_inst", 32'h0040_0100);

        // Redirect coincident with a response, then a second redirect.
        drain();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (mem_pc.size() > 0 && mem_rdy[0] <= cyc) hit = 1;
            else step(1'b0, 32'h0, 1'b0, 1'b1);
        end
        if (!hit) fail_timeout("rsp_wait");
        step(1'b1, 32'h0040_0200, 1'b1, 1'b1);
        step(1'b1, 32'h0040_0300, 1'b1, 1'b1);
        wait_inst("double_redir_inst", 32'h0040_0300);

        // PC wrap.
        lat_lo = 1; lat_hi = 2;
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("wrap_redir_pc_d", s_pc_d, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_req_addr", s_req_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_d",     s_pc_d,     32'h0000_0000);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset with a full buffer, then clean restart.
        lat_lo = 1; lat_hi = 1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (bq.size() == 2) hit = 1;
            else step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        if (!hit) fail_timeout("fill_buffer");
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("restart_req_valid", s_req_valid, 32'd1);
        chk("restart_req_addr",  s_req_addr,  32'h0040_0000);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            logic rd, rq, ir;
            logic [31:0] rpc;
            r   = $urandom;
            rd  = ($urandom_range(9, 0) == 0);
            rq  = ($urandom_range(3, 0) != 0);
            ir  = ($urandom_range(3, 0) != 0);
            rpc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | (r & 32'hF))
                                               : (32'h0040_0000 | (r & 32'hFFFF));
            step(rd, rpc, rq, ir);
            if (i % 700 == 699) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
